// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioner.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, debounce, registered edge pulses and auto-repeat.
// `release` is a reserved word, so the release pulse output is named release_pulse.
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 32,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   input  logic repeat_en,
   output logic held,
   output logic press,
   output logic release_pulse
);

   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic             sync1;
   logic             sync2;
   logic             s;
   logic             level;
   logic [DB_W-1:0]  db_cnt;
   logic             rise;
   logic             fall;
   logic             tick;
   rpt_state_t       state;
   rpt_state_t       state_next;
   logic [RPT_W-1:0] rcnt;
   logic [RPT_W-1:0] rcnt_next;

   // Synchroniser resets to the raw released level so a held button reads as a fresh press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   assign s = ~sync2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level  <= 1'b0;
         db_cnt <= '0;
      end else if (s == level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         level  <= s;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // The output stage lags level by one cycle, so their difference marks the edges.
   assign rise = level & ~held;
   assign fall = ~level & held;

   always_comb begin
      state_next = state;
      rcnt_next  = rcnt;
      tick       = 1'b0;
      case (state)
         IDLE: begin
            if (rise && repeat_en) begin
               state_next = DELAY;
               rcnt_next  = '0;
            end
         end
         DELAY: begin
            if (!repeat_en) begin
               state_next = IDLE;
            end else if (rcnt == DELAY_LAST) begin
               tick       = 1'b1;
               state_next = REPEAT;
               rcnt_next  = '0;
            end else begin
               rcnt_next = rcnt + 1'b1;
            end
         end
         REPEAT: begin
            if (!repeat_en) begin
               state_next = IDLE;
            end else if (rcnt == PERIOD_LAST) begin
               tick      = 1'b1;
               rcnt_next = '0;
            end else begin
               rcnt_next = rcnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      // A release always wins over a repeat tick landing in the same cycle.
      if (fall) begin
         state_next = IDLE;
         tick       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         rcnt  <= '0;
      end else begin
         state <= state_next;
         rcnt  <= rcnt_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         held          <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         held          <= level;
         press         <= rise | tick;
         release_pulse <= fall;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN active-low push buttons into held levels plus press/release pulses.
// Bit order is up, down, left, right; release pulses appear on release_pulse.
module button_conditioner #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 32,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_n,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] held,
   output logic [N_BTN-1:0] press,
   output logic [N_BTN-1:0] release_pulse
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .btn_n         (btn_n[i]),
         .repeat_en     (repeat_en[i]),
         .held          (held[i]),
         .press         (press[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, corner-case sequences and
// randomized inputs compared each cycle against a timing-level reference model.
module tb_button_conditioner;

   localparam int N  = 4;
   localparam int DB = 4;
   localparam int RD = 32;
   localparam int RP = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] btn_n;
   logic [N-1:0] repeat_en;
   logic [N-1:0] held;
   logic [N-1:0] press;
   logic [N-1:0] release_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .N_BTN           (N),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_n         (btn_n),
      .repeat_en     (repeat_en),
      .held          (held),
      .press         (press),
      .release_pulse (release_pulse)
   );

   // Reference model: raw samples age through a two-stage delay, a change is accepted
   // after DB consecutive disagreeing samples and shown one cycle later; repeat pulses
   // fall at RD, RD+RP, RD+2RP... cycles after the press pulse while armed.
   bit           m_s1[N];
   bit           m_s[N];
   bit           m_lvl[N];
   bit           m_armed[N];
   int           m_run[N];
   int           m_age[N];
   bit           m_rise;
   bit           m_fall;
   logic [N-1:0] m_held  = '0;
   logic [N-1:0] m_press = '0;
   logic [N-1:0] m_rel   = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            m_s1[i]    = 1'b0;
            m_s[i]     = 1'b0;
            m_lvl[i]   = 1'b0;
            m_armed[i] = 1'b0;
            m_run[i]   = 0;
            m_age[i]   = 0;
         end
         m_held  = '0;
         m_press = '0;
         m_rel   = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            m_rise     = m_lvl[i] && !m_held[i];
            m_fall     = !m_lvl[i] && m_held[i];
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            if (m_fall) begin
               m_rel[i]   = 1'b1;
               m_armed[i] = 1'b0;
            end else if (m_rise) begin
               m_press[i] = 1'b1;
               m_armed[i] = repeat_en[i];
               m_age[i]   = 0;
            end else if (m_armed[i]) begin
               if (!repeat_en[i]) begin
                  m_armed[i] = 1'b0;
               end else begin
                  m_age[i]   = m_age[i] + 1;
                  m_press[i] = (m_age[i] == RD) ||
                               (m_age[i] > RD && ((m_age[i] - RD) % RP) == 0);
               end
            end
            m_held[i] = m_lvl[i];
            if (m_s[i] == m_lvl[i]) begin
               m_run[i] = 0;
            end else begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == DB) begin
                  m_lvl[i] = m_s[i];
                  m_run[i] = 0;
               end
            end
            m_s[i]  = m_s1[i];
            m_s1[i] = !btn_n[i];
         end
      end
   end

   task automatic compareVec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compareInt(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [N-1:0] eh,
                              input logic [N-1:0] ep, input logic [N-1:0] er);
      compareVec({name, ".held"}, held, eh);
      compareVec({name, ".press"}, press, ep);
      compareVec({name, ".release"}, release_pulse, er);
   endtask

   task automatic applyStimulus(input logic [N-1:0] b, input logic [N-1:0] r, input int n);
      btn_n     = b;
      repeat_en = r;
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic waitPress(input int ch, output int lat);
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (press[ch]) begin
            lat = k;
            break;
         end
      end
   endtask

   // Continuous comparison against the model on every falling edge.
   always @(negedge clk) begin
      compareVec("model.held", held, m_held);
      compareVec("model.press", press, m_press);
      compareVec("model.release", release_pulse, m_rel);
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [N-1:0] b;
      logic [N-1:0] r;
      int           n;
      logic [N-1:0] h;
      logic [N-1:0] p;
      logic [N-1:0] e;
   } vec_t;

   vec_t vecs[$];
   int   lat;
   int   rate;

   initial begin
      vecs.push_back('{4'b1111, 4'b0000,  9, 4'b0000, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1110, 4'b0000,  6, 4'b0000, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1110, 4'b0000,  1, 4'b0001, 4'b0001, 4'b0000});
      vecs.push_back('{4'b1110, 4'b0000,  1, 4'b0001, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1111, 4'b0000,  6, 4'b0001, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1111, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0001});
      vecs.push_back('{4'b1111, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000});
      vecs.push_back('{4'b0101, 4'b0000,  7, 4'b1010, 4'b1010, 4'b0000});
      vecs.push_back('{4'b0101, 4'b0000, 10, 4'b1010, 4'b0000, 4'b0000});
      vecs.push_back('{4'b0101, 4'b1111, 40, 4'b1010, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1111, 4'b0000,  7, 4'b0000, 4'b0000, 4'b1010});
      vecs.push_back('{4'b1111, 4'b0000,  3, 4'b0000, 4'b0000, 4'b0000});
      for (int k = 0; k < 4; k++) begin
         vecs.push_back('{4'b1011, 4'b0000, 3, 4'b0000, 4'b0000, 4'b0000});
         vecs.push_back('{4'b1111, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000});
      end
      vecs.push_back('{4'b1011, 4'b0000,  6, 4'b0000, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1011, 4'b0000,  1, 4'b0100, 4'b0100, 4'b0000});
      vecs.push_back('{4'b1111, 4'b0000,  7, 4'b0000, 4'b0000, 4'b0100});
      vecs.push_back('{4'b1101, 4'b0010,  7, 4'b0010, 4'b0010, 4'b0000});
      vecs.push_back('{4'b1101, 4'b0010, 31, 4'b0010, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1101, 4'b0010,  1, 4'b0010, 4'b0010, 4'b0000});
      vecs.push_back('{4'b1101, 4'b0010,  4, 4'b0010, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1101, 4'b0000,  8, 4'b0010, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1101, 4'b0000,  4, 4'b0010, 4'b0000, 4'b0000});
      vecs.push_back('{4'b1111, 4'b0000,  7, 4'b0000, 4'b0000, 4'b0010});

      // Reset with every button held: all pressed arrives as a fresh press.
      reset     = 1'b0;
      btn_n     = 4'b0000;
      repeat_en = 4'b0000;
      repeat (3) @(negedge clk);
      checkOutput("reset_hold", 4'b0000, 4'b0000, 4'b0000);
      #2 reset = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_pre", 4'b0000, 4'b0000, 4'b0000);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_press", 4'b1111, 4'b1111, 4'b0000);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_after", 4'b1111, 4'b0000, 4'b0000);

      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(vecs[k].b, vecs[k].r, vecs[k].n);
         checkOutput($sformatf("vec%0d", k), vecs[k].h, vecs[k].p, vecs[k].e);
      end

      // Release debounced onto repeat offset 40: release only, no press.
      btn_n     = 4'b1110;
      repeat_en = 4'b0001;
      waitPress(0, lat);
      compareInt("coll_latency", lat, 6);
      for (int off = 1; off <= 40; off++) begin
         @(negedge clk);
         if (off == 32) checkOutput("coll_rpt32", 4'b0001, 4'b0001, 4'b0000);
         if (off == 33) btn_n = 4'b1111;
         if (off == 40) checkOutput("collision", 4'b0000, 4'b0000, 4'b0001);
      end
      repeat_en = 4'b0000;
      repeat (10) @(negedge clk);

      // Reset during REPEAT with the button still held.
      btn_n     = 4'b1101;
      repeat_en = 4'b0010;
      waitPress(1, lat);
      compareInt("rmid_latency", lat, 6);
      repeat (35) @(negedge clk);
      #2 reset = 1'b0;
      #1 checkOutput("rmid_async", 4'b0000, 4'b0000, 4'b0000);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("rmid_pre", 4'b0000, 4'b0000, 4'b0000);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rmid_press", 4'b0010, 4'b0010, 4'b0000);
      repeat (31) @(negedge clk);
      checkOutput("rmid_31", 4'b0010, 4'b0000, 4'b0000);
      @(negedge clk);
      checkOutput("rmid_32", 4'b0010, 4'b0010, 4'b0000);
      btn_n     = 4'b1111;
      repeat_en = 4'b0000;
      repeat (10) @(negedge clk);

      // Randomized bouncing and holding, checked by the model every cycle.
      rate = 8;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c % 200 == 0) rate = $urandom_range(2, 70);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(1, rate) == 1) btn_n[i] = ~btn_n[i];
            if ($urandom_range(1, 80) == 1) repeat_en[i] = ~repeat_en[i];
         end
         if (c == 1500) begin
            #2 reset = 1'b0;
            @(negedge clk);
            #2 reset = 1'b1;
         end
      end
      btn_n     = 4'b1111;
      repeat_en = 4'b0000;
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
